phys_free_list: RTL and testbench
=================================

PHYS_FREE_LIST -- requirements
Module: phys_free_list

Interface
REQ-001 The block SHALL have parameter NUM_PHYS, default 64, meaning number of physical registers (power of two).
REQ-002 The block SHALL have parameter NUM_ARCH, default 32, meaning number of architectural registers (RetRat entries).
REQ-003 The block SHALL have parameter PREG_W, default 6, meaning physical register ID width (log2 NUM_PHYS).
REQ-004 CLK  in  1  clock; all state SHALL update on posedge CLK.
REQ-005 RESET  in  1  reset, synchronous, active-low.
REQ-006 FREEZE  in  1  global stall; when high, all internal state SHALL hold.
REQ-007 tFL_free_flag_IN  in  1  commit-side request to return a physical register.
REQ-008 tFL_free_id_IN  in  PREG_W  physical register ID being returned.
REQ-009 tFL_alloc_req_IN  in  1  rename-side request to take the head ID.
REQ-010 fFL_alloc_id_OUT  out  PREG_W  ID at queue head; combinational from head entry.
REQ-011 fFL_alloc_valid_OUT  out  1  high when state is IDLE and count is nonzero.
REQ-012 tFL_recover_IN  in  1  flush/copy-RetRat pulse; triggers rebuild from RetRat.
REQ-013 tFL_retRat_IN  in  NUM_ARCH*PREG_W  RetRat image; entry 0 in the MSBs, entry NUM_ARCH-1 in the LSBs.
REQ-014 fFL_count_OUT  out  PREG_W+1  number of IDs currently held.
REQ-015 fFL_busy_OUT  out  1  high while in RECOVER.
REQ-016 fFL_overflow_OUT  out  1  sticky error: a free was dropped because the list was full.

Function
REQ-017 Storage SHALL be a circular queue of NUM_PHYS entries with head, tail and count registers; head and tail SHALL wrap modulo NUM_PHYS.
REQ-018 FSM states SHALL be IDLE and RECOVER, plus a scan index SCAN of PREG_W+1 bits and a latched RetRat copy.
REQ-019 In IDLE with FREEZE low, an alloc SHALL be accepted when tFL_alloc_req_IN and fFL_alloc_valid_OUT are both high; head then increments by 1 at the next edge.
REQ-020 In IDLE with FREEZE low and tFL_free_flag_IN high, the block SHALL write tFL_free_id_IN at tail and increment tail if count < NUM_PHYS; otherwise it drops the ID and sets fFL_overflow_OUT.
REQ-021 Simultaneous accepted alloc and free SHALL both take effect with count unchanged; there is no bypass, so a free when count==0 does not make alloc valid in the same cycle.
REQ-022 Count SHALL be +1 on free only, -1 on alloc only, and unchanged otherwise; it never exceeds NUM_PHYS or underflows.
REQ-023 tFL_recover_IN high with FREEZE low, in any state, SHALL take priority over alloc and free (both ignored that cycle); at the next edge: state=RECOVER, SCAN=0, head=tail=count=0, and tFL_retRat_IN latched.
REQ-024 In RECOVER, each non-frozen cycle SHALL examine ID=SCAN; if the ID matches none of the NUM_ARCH latched entries it is written at tail (tail+1, count+1); SCAN then increments.
REQ-025 After the cycle examining SCAN==NUM_PHYS-1, the block SHALL return to IDLE; recovery takes exactly NUM_PHYS unfrozen cycles, and alloc_valid is first possible on the following cycle.
REQ-026 Frees and allocs arriving during RECOVER SHALL be ignored, and fFL_alloc_valid_OUT SHALL stay low; the latched RetRat is authoritative.
REQ-027 A recover pulse during RECOVER SHALL restart the scan: re-latch the RetRat and reset SCAN/head/tail/count to 0.
REQ-028 With a RetRat containing K distinct IDs, the post-recovery count SHALL be NUM_PHYS-K, in ascending ID order from head; duplicates count once.
REQ-029 tFL_free_id_IN values SHALL NOT be range- or duplicate-checked.

Reset
REQ-030 On RESET low at posedge CLK, the block SHALL load state=IDLE, SCAN=0, head=0, tail=NUM_PHYS-NUM_ARCH, count=NUM_PHYS-NUM_ARCH, and entries 0..(NUM_PHYS-NUM_ARCH-1) holding IDs NUM_ARCH..NUM_PHYS-1 in order.
REQ-031 Reset SHALL also clear fFL_overflow_OUT and fFL_busy_OUT and set the latched RetRat to identity (entry r = r); reset SHALL override FREEZE and abort RECOVER mid-scan.
REQ-032 After reset, fFL_alloc_id_OUT SHALL be 32, fFL_alloc_valid_OUT 1 and fFL_count_OUT 32 (default parameters).

Verification
REQ-033 A bench SHALL check: reset, then alloc held for 33 cycles -> IDs 32..63 in order, count 0, alloc_valid low on the 33rd cycle.
REQ-034 A bench SHALL check: count 0, free ID 40 and alloc in the same cycle -> alloc not accepted; next cycle alloc_id 40, count 1.
REQ-035 A bench SHALL check: count 10, free ID 5 and alloc together for 4 cycles -> count stays 10 and the tail holds 5 four times.
REQ-036 A bench SHALL check: recover with RetRat entry r = r+32 -> busy for 64 cycles, then count 32, IDs 0..31 in order, alloc_valid high.
REQ-037 A bench SHALL check: recover, then at scan cycle 20 assert recover again with identity RetRat -> 64 more busy cycles, final list 32..63, and frees during the scan are ignored.
REQ-038 A bench SHALL check: FREEZE high for 5 cycles mid-recovery -> count/SCAN held and total busy time 69 cycles; then, with the list full (64), a free -> overflow sticks at 1 until reset.

Source files
------------

// File: rtl/phys_free_list_if.sv
// Rename/commit-side port bundle of the physical register free list.
// The master side is the rename/commit logic; the slave side is the free list itself.
interface phys_free_list_if #(
  parameter int NUM_ARCH = 32,
  parameter int PREG_W   = 6
);
  logic                       tFL_free_flag_IN;
  logic [PREG_W-1:0]          tFL_free_id_IN;
  logic                       tFL_alloc_req_IN;
  logic [PREG_W-1:0]          fFL_alloc_id_OUT;
  logic                       fFL_alloc_valid_OUT;
  logic                       tFL_recover_IN;
  logic [NUM_ARCH*PREG_W-1:0] tFL_retRat_IN;
  logic [PREG_W:0]            fFL_count_OUT;
  logic                       fFL_busy_OUT;
  logic                       fFL_overflow_OUT;

  modport master (
    output tFL_free_flag_IN, tFL_free_id_IN, tFL_alloc_req_IN, tFL_recover_IN, tFL_retRat_IN,
    input  fFL_alloc_id_OUT, fFL_alloc_valid_OUT, fFL_count_OUT, fFL_busy_OUT, fFL_overflow_OUT
  );
  modport slave (
    input  tFL_free_flag_IN, tFL_free_id_IN, tFL_alloc_req_IN, tFL_recover_IN, tFL_retRat_IN,
    output fFL_alloc_id_OUT, fFL_alloc_valid_OUT, fFL_count_OUT, fFL_busy_OUT, fFL_overflow_OUT
  );
endinterface

// File: rtl/phys_free_list.sv
// Circular free list of physical register IDs. A recover pulse rebuilds the list
// by scanning every ID and keeping only those absent from the latched RetRat.
module phys_free_list #(
  parameter int NUM_PHYS = 64,
  parameter int NUM_ARCH = 32,
  parameter int PREG_W   = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FREEZE,
  phys_free_list_if.slave  bus
);
  typedef enum logic {S_IDLE = 1'b0, S_RECOVER = 1'b1} state_t;

  localparam logic [PREG_W:0]   FULL     = (PREG_W+1)'(NUM_PHYS);
  localparam logic [PREG_W:0]   INIT_CNT = (PREG_W+1)'(NUM_PHYS - NUM_ARCH);
  localparam logic [PREG_W-1:0] LAST_ID  = PREG_W'(NUM_PHYS - 1);

  state_t                             state_q, state_d;
  logic [PREG_W:0]                    scan_q, scan_d;
  logic [PREG_W-1:0]                  head_q, head_d, tail_q, tail_d;
  logic [PREG_W:0]                    count_q, count_d;
  logic [NUM_PHYS-1:0][PREG_W-1:0]    mem_q, mem_d;
  logic [NUM_ARCH-1:0][PREG_W-1:0]    rat_q, rat_d;
  logic                               ovf_q, ovf_d;

  logic              alloc_ok, free_ok, hit;
  logic [PREG_W-1:0] scan_id;

  // state register
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      scan_q  <= '0;
      head_q  <= '0;
      tail_q  <= INIT_CNT[PREG_W-1:0];
      count_q <= INIT_CNT;
      ovf_q   <= 1'b0;
      for (int i = 0; i < NUM_PHYS; i++)
        mem_q[i] <= (i < NUM_PHYS - NUM_ARCH) ? PREG_W'(i + NUM_ARCH) : '0;
      for (int r = 0; r < NUM_ARCH; r++)
        rat_q[r] <= PREG_W'(r);
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      mem_q   <= mem_d;
      rat_q   <= rat_d;
    end
  end

  assign scan_id = scan_q[PREG_W-1:0];

  always_comb begin
    hit = 1'b0;
    for (int r = 0; r < NUM_ARCH; r++)
      if (rat_q[r] == scan_id) hit = 1'b1;
  end

  // next-state and datapath
  always_comb begin
    state_d  = state_q;
    scan_d   = scan_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    mem_d    = mem_q;
    rat_d    = rat_q;
    alloc_ok = 1'b0;
    free_ok  = 1'b0;
    if (!FREEZE) begin
      if (bus.tFL_recover_IN) begin
        state_d = S_RECOVER;
        scan_d  = '0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        for (int r = 0; r < NUM_ARCH; r++)
          rat_d[r] = bus.tFL_retRat_IN[(NUM_ARCH-1-r)*PREG_W +: PREG_W];
      end else if (state_q == S_RECOVER) begin
        if (!hit) begin
          mem_d[tail_q] = scan_id;
          tail_d        = tail_q + PREG_W'(1);
          count_d       = count_q + (PREG_W+1)'(1);
        end
        scan_d = scan_q + (PREG_W+1)'(1);
        if (scan_id == LAST_ID) state_d = S_IDLE;
      end else begin
        // count checks use the pre-edge value: no free-to-alloc bypass
        alloc_ok = bus.tFL_alloc_req_IN && (count_q != '0);
        free_ok  = bus.tFL_free_flag_IN && (count_q < FULL);
        if (bus.tFL_free_flag_IN && !free_ok) ovf_d = 1'b1;
        if (alloc_ok) head_d = head_q + PREG_W'(1);
        if (free_ok) begin
          mem_d[tail_q] = bus.tFL_free_id_IN;
          tail_d        = tail_q + PREG_W'(1);
        end
        if (free_ok && !alloc_ok)      count_d = count_q + (PREG_W+1)'(1);
        else if (alloc_ok && !free_ok) count_d = count_q - (PREG_W+1)'(1);
      end
    end
  end

  // outputs
  always_comb begin
    bus.fFL_alloc_id_OUT    = mem_q[head_q];
    bus.fFL_alloc_valid_OUT = (state_q == S_IDLE) && (count_q != '0);
    bus.fFL_count_OUT       = count_q;
    bus.fFL_busy_OUT        = (state_q == S_RECOVER);
    bus.fFL_overflow_OUT    = ovf_q;
  end
endmodule

// File: tb/tb_phys_free_list.sv
// Directed + random bench for phys_free_list against a queue-based reference model.
module tb_phys_free_list;
  localparam int NP = 64;
  localparam int NA = 32;
  localparam int W  = 6;

  logic CLK, RESET, FREEZE;
  phys_free_list_if #(.NUM_ARCH(NA), .PREG_W(W)) bus ();

  phys_free_list #(.NUM_PHYS(NP), .NUM_ARCH(NA), .PREG_W(W)) dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .bus(bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // reference model: the free list as a plain queue of IDs
  int q[$];
  bit m_busy, m_ovf;
  int m_scan;
  int m_rat[NA];
  int n_assert = 0, n_fail = 0;

  task automatic model_step();
    bit a, f, hit;
    if (!RESET) begin
      q.delete();
      for (int i = NA; i < NP; i++) q.push_back(i);
      m_busy = 0; m_scan = 0; m_ovf = 0;
      for (int r = 0; r < NA; r++) m_rat[r] = r;
    end else if (FREEZE) begin
    end else if (bus.tFL_recover_IN) begin
      q.delete();
      m_busy = 1; m_scan = 0;
      for (int r = 0; r < NA; r++) m_rat[r] = int'(bus.tFL_retRat_IN[(NA-1-r)*W +: W]);
    end else if (m_busy) begin
      hit = 0;
      foreach (m_rat[r]) if (m_rat[r] == m_scan) hit = 1;
      if (!hit) q.push_back(m_scan);
      if (m_scan == NP-1) m_busy = 0;
      m_scan++;
    end else begin
      a = bus.tFL_alloc_req_IN && q.size() != 0;
      f = bus.tFL_free_flag_IN && q.size() < NP;
      if (bus.tFL_free_flag_IN && !f) m_ovf = 1;
      if (a) void'(q.pop_front());
      if (f) q.push_back(int'(bus.tFL_free_id_IN));
    end
  endtask

  task automatic check(string tag);
    bit ev;
    ev = !m_busy && q.size() != 0;
    n_assert++;
    assert (bus.fFL_alloc_valid_OUT === ev) else begin
      n_fail++; $error("FAIL %s valid got %0b exp %0b", tag, bus.fFL_alloc_valid_OUT, ev);
    end
    n_assert++;
    assert (bus.fFL_count_OUT === 7'(q.size())) else begin
      n_fail++; $error("FAIL %s count got %0d exp %0d", tag, bus.fFL_count_OUT, q.size());
    end
    n_assert++;
    assert (bus.fFL_busy_OUT === m_busy) else begin
      n_fail++; $error("FAIL %s busy got %0b exp %0b", tag, bus.fFL_busy_OUT, m_busy);
    end
    n_assert++;
    assert (bus.fFL_overflow_OUT === m_ovf) else begin
      n_fail++; $error("FAIL %s overflow got %0b exp %0b", tag, bus.fFL_overflow_OUT, m_ovf);
    end
    if (ev) begin
      n_assert++;
      assert (bus.fFL_alloc_id_OUT === 6'(q[0])) else begin
        n_fail++; $error("FAIL %s alloc_id got %0d exp %0d", tag, bus.fFL_alloc_id_OUT, q[0]);
      end
    end
  endtask

  task automatic step(string tag);
    @(posedge CLK);
    model_step();
    #1;
    check(tag);
  endtask

  task automatic idle_inputs();
    bus.tFL_free_flag_IN = 0; bus.tFL_free_id_IN = '0;
    bus.tFL_alloc_req_IN = 0; bus.tFL_recover_IN = 0;
  endtask

  task automatic set_rat(input int base, input bit rnd);
    logic [NA*W-1:0] v;
    for (int r = 0; r < NA; r++)
      v[(NA-1-r)*W +: W] = rnd ? W'($urandom_range(NP-1)) : W'(r + base);
    bus.tFL_retRat_IN = v;
  endtask

  // counts cycles until busy drops, bounded
  task automatic wait_idle(string tag, output int n);
    n = 0;
    while (bus.fFL_busy_OUT && n < 300) begin
      step(tag); n++;
    end
  endtask

  task automatic expect_int(string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++; $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  initial begin
    int n, busy_total;
    RESET = 0; FREEZE = 0;
    idle_inputs();
    set_rat(0, 0);
    step("reset");
    expect_int("reset_id", int'(bus.fFL_alloc_id_OUT), 32);
    expect_int("reset_cnt", int'(bus.fFL_count_OUT), 32);
    RESET = 1;

    // drain: IDs 32..63, then empty
    bus.tFL_alloc_req_IN = 1;
    for (int i = 0; i < 33; i++) step("drain");
    expect_int("drain_cnt", int'(bus.fFL_count_OUT), 0);
    bus.tFL_alloc_req_IN = 0;

    // free+alloc on empty: no bypass
    bus.tFL_free_flag_IN = 1; bus.tFL_free_id_IN = 6'd40; bus.tFL_alloc_req_IN = 1;
    step("nobypass");
    expect_int("nobypass_id", int'(bus.fFL_alloc_id_OUT), 40);
    bus.tFL_alloc_req_IN = 0;
    for (int i = 1; i <= 9; i++) begin
      bus.tFL_free_id_IN = W'(i); step("fill10");
    end
    bus.tFL_free_id_IN = 6'd5; bus.tFL_alloc_req_IN = 1;
    for (int i = 0; i < 4; i++) step("swap");
    expect_int("swap_cnt", int'(bus.fFL_count_OUT), 10);
    bus.tFL_free_flag_IN = 0;
    for (int i = 0; i < 11; i++) step("swap_drain");
    bus.tFL_alloc_req_IN = 0;

    // recover with RetRat r+32 -> list 0..31
    set_rat(32, 0); bus.tFL_recover_IN = 1; step("rec1");
    bus.tFL_recover_IN = 0;
    wait_idle("rec1_scan", n);
    expect_int("rec1_busy", n, 64);
    bus.tFL_alloc_req_IN = 1;
    for (int i = 0; i < 32; i++) step("rec1_drain");
    bus.tFL_alloc_req_IN = 0;

    // restart mid-scan with identity, frees ignored
    set_rat(32, 0); bus.tFL_recover_IN = 1; step("rec2");
    bus.tFL_recover_IN = 0; bus.tFL_free_flag_IN = 1; bus.tFL_free_id_IN = 6'd7;
    for (int i = 0; i < 20; i++) step("rec2_scan");
    set_rat(0, 0); bus.tFL_recover_IN = 1; step("rec2_restart");
    bus.tFL_recover_IN = 0;
    wait_idle("rec2_scan2", n);
    expect_int("rec2_busy", n, 64);
    bus.tFL_free_flag_IN = 0;
    expect_int("rec2_cnt", int'(bus.fFL_count_OUT), 32);
    expect_int("rec2_head", int'(bus.fFL_alloc_id_OUT), 32);

    // freeze mid-recovery; all-zero RetRat leaves 63 entries
    set_rat(0, 0); bus.tFL_retRat_IN = '0; bus.tFL_recover_IN = 1; step("rec3");
    bus.tFL_recover_IN = 0;
    for (int i = 0; i < 10; i++) step("rec3_scan");
    FREEZE = 1;
    for (int i = 0; i < 5; i++) step("rec3_frz");
    FREEZE = 0;
    wait_idle("rec3_rest", n);
    busy_total = 15 + n;
    expect_int("rec3_busy", busy_total, 69);
    bus.tFL_free_flag_IN = 1; bus.tFL_free_id_IN = 6'd0;
    step("fill64");
    bus.tFL_free_id_IN = 6'd9;
    step("ovf");
    bus.tFL_free_flag_IN = 0; bus.tFL_alloc_req_IN = 1;
    for (int i = 0; i < 5; i++) step("ovf_sticky");
    bus.tFL_alloc_req_IN = 0;
    RESET = 0; step("ovf_reset");
    RESET = 1;

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bus.tFL_free_flag_IN = ($urandom_range(2) != 0);
      bus.tFL_free_id_IN   = W'($urandom_range(NP-1));
      bus.tFL_alloc_req_IN = ($urandom_range(2) != 0);
      bus.tFL_recover_IN   = ($urandom_range(99) == 0);
      if (bus.tFL_recover_IN) set_rat(0, 1);
      FREEZE = ($urandom_range(9) == 0);
      RESET  = ($urandom_range(299) != 0);
      step("rand");
    end
    RESET = 1; FREEZE = 0; idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
